// File: rtl/uii2c_slave.sv
// uii2c_slave: I2C target answering one fixed 7-bit address, with an
// auto-incrementing 8-bit register pointer port. SCL/SDA are oversampled and glitch filtered.
module uii2c_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h3C,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       iic_scl,
  inout  wire        iic_sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       iic_busy,
  output logic       sda_dg
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_t;

  logic [1:0]          scl_sync, sda_sync;
  logic [FILT_LEN-2:0] scl_hist, sda_hist;
  logic [FILT_LEN-1:0] scl_win, sda_win;
  logic                scl_filt, sda_filt, scl_prev, sda_prev;
  logic                scl_rise, scl_fall, start_det, stop_det;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg, txbuf;
  logic       rw_reg, nack_reg, cap_pend, drv_pend, inc_pend, sda_oe;

  // The window holds the newest synchronized sample plus FILT_LEN-1 older ones.
  assign scl_win = {scl_hist, scl_sync[1]};
  assign sda_win = {sda_hist, sda_sync[1]};

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_filt <= 1'b1;
      sda_filt <= 1'b1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], iic_scl};
      sda_sync <= {sda_sync[0], iic_sda};
      scl_hist <= scl_win[FILT_LEN-2:0];
      sda_hist <= sda_win[FILT_LEN-2:0];
      if (&scl_win) scl_filt <= 1'b1;
      else if (~|scl_win) scl_filt <= 1'b0;
      if (&sda_win) sda_filt <= 1'b1;
      else if (~|sda_win) sda_filt <= 1'b0;
      scl_prev <= scl_filt;
      sda_prev <= sda_filt;
    end
  end

  assign scl_rise  = scl_filt & ~scl_prev;
  assign scl_fall  = ~scl_filt & scl_prev;
  assign start_det = scl_filt & scl_prev & sda_prev & ~sda_filt;
  assign stop_det  = scl_filt & scl_prev & ~sda_prev & sda_filt;
  assign sda_dg    = sda_filt;
  assign iic_sda   = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shreg     <= 8'd0;
      txbuf     <= 8'd0;
      rw_reg    <= 1'b0;
      nack_reg  <= 1'b0;
      cap_pend  <= 1'b0;
      drv_pend  <= 1'b0;
      inc_pend  <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= 8'd0;
      reg_wdata <= 8'd0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      iic_busy  <= 1'b0;
    end else begin
      reg_we   <= 1'b0;
      reg_re   <= 1'b0;
      inc_pend <= 1'b0;
      cap_pend <= reg_re;
      drv_pend <= cap_pend;
      if (inc_pend) reg_addr <= reg_addr + 8'd1;
      // Read byte pipeline: strobe, capture one cycle later, drive MSB the next.
      if (cap_pend) begin
        txbuf    <= reg_rdata;
        reg_addr <= reg_addr + 8'd1;
      end
      if (drv_pend && state == RDATA) sda_oe <= ~txbuf[7];

      if (stop_det) begin
        state    <= IDLE;
        sda_oe   <= 1'b0;
        iic_busy <= 1'b0;
      end else if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda_filt};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (state == ADDR) begin
                if (shreg[7:1] == DEV_ADDR) begin
                  state    <= ADDR_ACK;
                  rw_reg   <= shreg[0];
                  sda_oe   <= 1'b1;
                  iic_busy <= 1'b1;
                end else begin
                  state <= IGNORE;
                end
              end else if (state == PTR) begin
                reg_addr <= shreg;
                state    <= PTR_ACK;
                sda_oe   <= 1'b1;
              end else begin
                reg_we    <= 1'b1;
                reg_wdata <= shreg;
                inc_pend  <= 1'b1;
                state     <= WDATA_ACK;
                sda_oe    <= 1'b1;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              if (rw_reg) begin
                reg_re <= 1'b1;
                state  <= RDATA;
              end else begin
                state <= PTR;
              end
            end
          end
          PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= WDATA;
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              sda_oe  <= 1'b0;
              state   <= RACK;
            end else if (scl_fall && bit_cnt != 4'd0) begin
              txbuf  <= {txbuf[6:0], 1'b0};
              sda_oe <= ~txbuf[6];
            end
          end
          RACK: begin
            if (scl_rise) begin
              nack_reg <= sda_filt;
            end else if (scl_fall) begin
              if (!nack_reg) begin
                reg_re <= 1'b1;
                state  <= RDATA;
              end else begin
                state <= IGNORE;
              end
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uii2c_slave.sv
// Bench for uii2c_slave: a bit-banged I2C master, a register stub returning
// addr ^ 8'hFF, table-driven protocol cases, corner sequences and random traffic.
module tb_uii2c_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        sda_bus;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, iic_busy, sda_dg;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);
  assign reg_rdata = reg_addr ^ 8'hFF;

  uii2c_slave dut (
    .clk_i     (clk),
    .rst_n     (rst_n),
    .iic_scl   (scl),
    .iic_sda   (sda_bus),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .iic_busy  (iic_busy),
    .sda_dg    (sda_dg)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] we_q[$];
  int          re_cnt = 0;
  logic        busy_seen = 1'b0;
  logic        slave_low_seen = 1'b0;
  logic [7:0]  glitch_mask = 8'h00;
  logic [7:0]  m_ptr = 8'h00;

  always @(negedge clk) begin
    if (reg_we) we_q.push_back({reg_addr, reg_wdata});
    if (reg_re) re_cnt++;
    if (reg_we && reg_re) begin
      errors++;
      $display("FAIL strobe_overlap: reg_we=1 reg_re=1, required never both");
    end
    if (iic_busy) busy_seen = 1'b1;
    if (!sda_bus && !m_sda_low) slave_low_seen = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_cycle(input logic drive_low, input logic gl, output logic s);
    wait_clk(8);
    m_sda_low = drive_low;
    wait_clk(8);
    scl = 1'b1;
    wait_clk(8);
    s = sda_bus;
    if (gl) begin
      m_sda_low = ~m_sda_low;
      wait_clk(1);
      m_sda_low = ~m_sda_low;
    end
    wait_clk(8);
    scl = 1'b0;
  endtask

  task automatic bus_start();
    wait_clk(4);
    m_sda_low = 1'b0;
    wait_clk(8);
    scl = 1'b1;
    wait_clk(8);
    m_sda_low = 1'b1;
    wait_clk(8);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(4);
    m_sda_low = 1'b1;
    wait_clk(8);
    scl = 1'b1;
    wait_clk(8);
    m_sda_low = 1'b0;
    wait_clk(12);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] gmask, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(~b[i], gmask[i], s);
    bit_cycle(1'b0, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b0, 1'b0, s);
      b[i] = s;
    end
    bit_cycle(~nack, 1'b0, s);
  endtask

  task automatic run_txn(input logic rd, input logic setp, input logic [6:0] dev,
                         input logic [7:0] ptr, input int n, input logic [31:0] wdat,
                         input logic exp_ack, input logic [31:0] exp_wa,
                         input logic [31:0] exp_rd, input logic [7:0] exp_ptr,
                         input string tag);
    logic       a;
    logic [7:0] b;
    int         exp_we;
    we_q.delete();
    re_cnt = 0;
    busy_seen = 1'b0;
    slave_low_seen = 1'b0;
    bus_start();
    if (!rd || setp) begin
      send_byte({dev, 1'b0}, 8'h00, a);
      check($sformatf("%s addr_w_ack", tag), 32'(a), 32'(exp_ack));
      send_byte(ptr, 8'h00, a);
      check($sformatf("%s ptr_ack", tag), 32'(a), 32'(exp_ack));
      if (!rd) begin
        for (int i = 0; i < n; i++) begin
          send_byte(wdat[31-8*i -: 8], (i == 0) ? glitch_mask : 8'h00, a);
          check($sformatf("%s data%0d_ack", tag, i), 32'(a), 32'(exp_ack));
        end
      end else begin
        bus_start();
      end
    end
    if (rd) begin
      send_byte({dev, 1'b1}, 8'h00, a);
      check($sformatf("%s addr_r_ack", tag), 32'(a), 32'(exp_ack));
      for (int i = 0; i < n; i++) begin
        read_byte(i == n - 1, b);
        check($sformatf("%s rbyte%0d", tag, i), 32'(b), 32'(exp_rd[31-8*i -: 8]));
      end
    end
    bus_stop();
    exp_we = (exp_ack && !rd) ? n : 0;
    $display("txn %s: rd=%0b dev=%0h ptr=%0h n=%0d reg_addr=%0h we=%0d re=%0d",
             tag, rd, dev, ptr, n, reg_addr, we_q.size(), re_cnt);
    check($sformatf("%s reg_addr", tag), 32'(reg_addr), 32'(exp_ptr));
    check($sformatf("%s busy_after_stop", tag), 32'(iic_busy), 32'd0);
    check($sformatf("%s busy_seen", tag), 32'(busy_seen), 32'(exp_ack));
    check($sformatf("%s we_count", tag), 32'(we_q.size()), 32'(exp_we));
    check($sformatf("%s re_count", tag), 32'(re_cnt), (exp_ack && rd) ? 32'(n) : 32'd0);
    for (int i = 0; i < exp_we && i < we_q.size(); i++) begin
      check($sformatf("%s we%0d", tag, i), 32'(we_q[i]),
            32'({exp_wa[31-8*i -: 8], wdat[31-8*i -: 8]}));
    end
    if (!exp_ack) check($sformatf("%s sda_untouched", tag), 32'(slave_low_seen), 32'd0);
  endtask

  typedef struct packed {
    logic        rd;
    logic        setp;
    logic [6:0]  dev;
    logic [7:0]  ptr;
    logic [2:0]  n;
    logic [31:0] wdat;
    logic        exp_ack;
    logic [31:0] exp_wa;
    logic [31:0] exp_rd;
    logic [7:0]  exp_ptr;
  } vec_t;

  initial begin
    vec_t        vecs[4];
    logic        a, s;
    logic [7:0]  ptr;
    logic [6:0]  dev;
    logic [31:0] wdat, exp_wa, exp_rd;
    int          n, kind;

    vecs[0] = '{1'b0, 1'b0, 7'h3C, 8'h10, 3'd2, 32'hA55A0000, 1'b1, 32'h10110000, 32'h0, 8'h12};
    vecs[1] = '{1'b1, 1'b1, 7'h3C, 8'h20, 3'd3, 32'h0, 1'b1, 32'h0, 32'hDFDEDD00, 8'h23};
    vecs[2] = '{1'b0, 1'b0, 7'h3D, 8'h00, 3'd0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h23};
    vecs[3] = '{1'b0, 1'b0, 7'h3C, 8'hFF, 3'd2, 32'h11220000, 1'b1, 32'hFF000000, 32'h0, 8'h01};

    wait_clk(3);
    check("rst sda_released", 32'(sda_bus), 32'd1);
    check("rst reg_addr", 32'(reg_addr), 32'd0);
    check("rst reg_wdata", 32'(reg_wdata), 32'd0);
    check("rst reg_we", 32'(reg_we), 32'd0);
    check("rst reg_re", 32'(reg_re), 32'd0);
    check("rst iic_busy", 32'(iic_busy), 32'd0);
    check("rst sda_dg", 32'(sda_dg), 32'd1);
    rst_n = 1'b1;
    wait_clk(10);

    for (int v = 0; v < 4; v++) begin
      run_txn(vecs[v].rd, vecs[v].setp, vecs[v].dev, vecs[v].ptr, int'(vecs[v].n),
              vecs[v].wdat, vecs[v].exp_ack, vecs[v].exp_wa, vecs[v].exp_rd,
              vecs[v].exp_ptr, $sformatf("vec%0d", v));
    end
    m_ptr = 8'h01;

    // 1-cycle SDA glitches while SCL is high: fake START on a 1 bit, fake STOP on a 0 bit.
    glitch_mask = 8'b1000_0001;
    run_txn(1'b0, 1'b0, 7'h3C, 8'h40, 1, 32'hF0000000, 1'b1, 32'h40000000, 32'h0, 8'h41, "glitch");
    glitch_mask = 8'h00;
    m_ptr = 8'h41;

    // STOP after four bits of a data byte: pointer set, no write strobe.
    we_q.delete();
    bus_start();
    send_byte(8'h78, 8'h00, a);
    check("midstop addr_ack", 32'(a), 32'd1);
    send_byte(8'h50, 8'h00, a);
    check("midstop ptr_ack", 32'(a), 32'd1);
    bit_cycle(1'b0, 1'b0, s);
    bit_cycle(1'b0, 1'b0, s);
    bit_cycle(1'b1, 1'b0, s);
    bit_cycle(1'b1, 1'b0, s);
    bus_stop();
    $display("txn midstop: reg_addr=%0h we=%0d busy=%0b", reg_addr, we_q.size(), iic_busy);
    check("midstop we_count", 32'(we_q.size()), 32'd0);
    check("midstop busy", 32'(iic_busy), 32'd0);
    check("midstop reg_addr", 32'(reg_addr), 32'h50);
    m_ptr = 8'h50;

    // Reset pulsed while the target drives a 0 data bit (0xF0 ^ 0xFF = 0x0F).
    bus_start();
    send_byte(8'h78, 8'h00, a);
    check("rstrd addr_w_ack", 32'(a), 32'd1);
    send_byte(8'hF0, 8'h00, a);
    check("rstrd ptr_ack", 32'(a), 32'd1);
    bus_start();
    send_byte(8'h79, 8'h00, a);
    check("rstrd addr_r_ack", 32'(a), 32'd1);
    wait_clk(8);
    m_sda_low = 1'b0;
    wait_clk(8);
    scl = 1'b1;
    wait_clk(8);
    check("rstrd bit_driven", 32'(sda_bus), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rstrd sda_released", 32'(sda_bus), 32'd1);
    wait_clk(2);
    check("rstrd reg_addr", 32'(reg_addr), 32'd0);
    check("rstrd busy", 32'(iic_busy), 32'd0);
    rst_n = 1'b1;
    wait_clk(8);
    scl = 1'b0;
    bus_stop();
    $display("txn rstrd: reg_addr=%0h busy=%0b", reg_addr, iic_busy);
    check("rstrd after_stop_addr", 32'(reg_addr), 32'd0);
    m_ptr = 8'h00;

    // Random traffic against the pointer/register model.
    for (int k = 0; k < 10; k++) begin
      kind = int'($urandom_range(0, 3));
      dev = 7'h3C;
      ptr = 8'($urandom);
      wdat = $urandom;
      exp_wa = 32'h0;
      exp_rd = 32'h0;
      case (kind)
        0: begin
          n = int'($urandom_range(0, 4));
          for (int i = 0; i < n; i++) exp_wa[31-8*i -: 8] = 8'(ptr + 8'(i));
          run_txn(1'b0, 1'b0, dev, ptr, n, wdat, 1'b1, exp_wa, exp_rd,
                  8'(ptr + 8'(n)), $sformatf("rnd%0d_wr", k));
          m_ptr = 8'(ptr + 8'(n));
        end
        1: begin
          n = int'($urandom_range(1, 4));
          for (int i = 0; i < n; i++) exp_rd[31-8*i -: 8] = 8'(ptr + 8'(i)) ^ 8'hFF;
          run_txn(1'b1, 1'b1, dev, ptr, n, wdat, 1'b1, exp_wa, exp_rd,
                  8'(ptr + 8'(n)), $sformatf("rnd%0d_rd", k));
          m_ptr = 8'(ptr + 8'(n));
        end
        2: begin
          n = int'($urandom_range(1, 4));
          for (int i = 0; i < n; i++) exp_rd[31-8*i -: 8] = 8'(m_ptr + 8'(i)) ^ 8'hFF;
          run_txn(1'b1, 1'b0, dev, ptr, n, wdat, 1'b1, exp_wa, exp_rd,
                  8'(m_ptr + 8'(n)), $sformatf("rnd%0d_cur", k));
          m_ptr = 8'(m_ptr + 8'(n));
        end
        default: begin
          n = int'($urandom_range(0, 2));
          dev = 7'($urandom);
          if (dev == 7'h3C) dev = 7'h3D;
          run_txn(1'b0, 1'b0, dev, ptr, n, wdat, 1'b0, exp_wa, exp_rd,
                  m_ptr, $sformatf("rnd%0d_nm", k));
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
